// File: rtl/prio_arb_pkg.sv
// Shared types for the prio_arb_ctrl arbiter: FSM state encoding and debug names.
package prio_arb_pkg;

  // 2-bit state encoding; values are fixed so waveforms and debug dumps stay stable.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DRAIN   = 2'd2,
    RECOVER = 2'd3
  } state_t;

`ifndef SYNTHESIS
  // Human-readable state name for assertion and debug messages.
  function automatic string state_name(state_t s);
    case (s)
      IDLE:    return "IDLE";
      BUSY:    return "BUSY";
      DRAIN:   return "DRAIN";
      RECOVER: return "RECOVER";
      default: return "UNKNOWN";
    endcase
  endfunction
`endif

endpackage

// File: rtl/prio_arb_pick.sv
// Combinational requester picker: first set request found searching upward from
// start with wrap-around. start=0 gives plain fixed priority (lowest index wins).
module prio_arb_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Walk all N positions from start; the first hit wins, later hits are ignored.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (int'(start) + i) % N;
      if (!any && req[j[IDW-1:0]]) begin
        idx = j[IDW-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arb_ctrl.sv
// Arbiter/sequencer sharing one single-ported resource between N requesters.
// req/gnt handshake, done-based release, bounded hold timer with timeout pulse.
// All outputs are registered from the next state.
// Optional macro PRIO_ARB_RR_EN: round-robin arbitration instead of fixed priority.
module prio_arb_ctrl
  import prio_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int TMO = 16,
  parameter int IDW = $clog2(N),
  parameter int CW  = $clog2(TMO + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] owner_d;
  logic [N-1:0]   gnt_d;
  logic           busy_d;
  logic           timeout_d;

  logic [IDW-1:0] pick_start;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;

`ifdef PRIO_ARB_RR_EN
  logic [IDW-1:0] ptr_q;

  // Search begins just after the last owner so every requester gets a turn.
  always_comb begin
    pick_start = (ptr_q == IDW'(N - 1)) ? '0 : ptr_q + IDW'(1);
  end

  // Remember the owner of each new grant; reset points at N-1 so requester 0 is first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IDW'(N - 1);
    end else if (state_q == IDLE && state_d == BUSY) begin
      ptr_q <= owner_d;
    end
  end
`else
  // Fixed priority: always search from requester 0.
  always_comb begin
    pick_start = '0;
  end
`endif

  prio_arb_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (req),
    .start (pick_start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next-state, owner capture, hold counter and timeout decision.
  always_comb begin
    state_d   = state_q;
    owner_d   = gnt_id;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;

    // Hold counter runs while the resource is owned and sticks at TMO.
    if ((state_q == BUSY || state_q == DRAIN) && cnt_q != CW'(TMO)) begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // done has priority over withdrawal and the hold limit.
        if (done) begin
          state_d = RECOVER;
        end else if (!req[gnt_id]) begin
          state_d = DRAIN;
        end else if (cnt_q == CW'(TMO - 1)) begin
          state_d   = RECOVER;
          timeout_d = 1'b1;
        end
      end
      DRAIN: begin
        if (done) begin
          state_d = RECOVER;
        end else if (cnt_q == CW'(TMO - 1)) begin
          state_d   = RECOVER;
          timeout_d = 1'b1;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values as they will look once the next state is entered.
  always_comb begin
    gnt_d  = (state_d == BUSY) ? (N'(1) << owner_d) : '0;
    busy_d = (state_d == BUSY) || (state_d == DRAIN);
  end

  // State, counter and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      gnt_id  <= owner_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

`ifndef SYNTHESIS
  // Grants are exclusive and only exist while the resource is owned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt))
      else $error("prio_arb_ctrl: non-onehot gnt=%b in %s", gnt, state_name(state_q));
      assert (gnt == '0 || busy)
      else $error("prio_arb_ctrl: gnt=%b without busy in %s", gnt, state_name(state_q));
    end
  end
`endif

endmodule

// File: tb/tb_prio_arb_ctrl.sv
// Scoreboard bench for prio_arb_ctrl (N=4, TMO=16). Stimulus pushes expected
// outputs tagged with a cycle number; a monitor pops and compares on the falling edge.
module tb_prio_arb_ctrl;
  import prio_arb_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
    state_t     st;
  } exp_t;

  exp_t sb[$];

  prio_arb_ctrl #(
    .N   (N),
    .TMO (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compare every expectation queued for the current cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt_id !== e.id || busy !== e.busy || timeout !== e.to ||
          dut.state_q !== e.st) begin
        errors++;
        $display("FAIL %s @cyc %0d: got gnt=%b id=%0d busy=%b to=%b st=%s, want gnt=%b id=%0d busy=%b to=%b st=%s",
                 e.name, cyc, gnt, gnt_id, busy, timeout, state_name(dut.state_q),
                 e.gnt, e.id, e.busy, e.to, state_name(e.st));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] id,
                            input logic b, input logic t, input state_t s);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.gnt  = g;
    e.id   = id;
    e.busy = b;
    e.to   = t;
    e.st   = s;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    done = 1'b0;
    tick();
    expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0, IDLE);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] eid;
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;

    // 1: reset with all requests held, first grant goes to requester 0.
    tick();
    expect_out("t1_rst_a", 4'b0000, 2'd0, 1'b0, 1'b0, IDLE);
    tick();
    expect_out("t1_rst_b", 4'b0000, 2'd0, 1'b0, 1'b0, IDLE);
    rst = 1'b0;
    tick();
    expect_out("t1_first_gnt", 4'b0001, 2'd0, 1'b1, 1'b0, BUSY);
    req  = 4'b0000;
    done = 1'b1;
    tick();
    expect_out("t1_release", 4'b0000, 2'd0, 1'b0, 1'b0, RECOVER);
    done = 1'b0;
    tick();
    expect_out("t1_idle", 4'b0000, 2'd0, 1'b0, 1'b0, IDLE);

    // 2: priority pick, release on done, re-grant two cycles after RECOVER.
    do_reset();
    req = 4'b1010;
    tick();
    expect_out("t2_gnt", 4'b0010, 2'd1, 1'b1, 1'b0, BUSY);
    tick();
    expect_out("t2_hold", 4'b0010, 2'd1, 1'b1, 1'b0, BUSY);
    done = 1'b1;
    tick();
    expect_out("t2_recover", 4'b0000, 2'd1, 1'b0, 1'b0, RECOVER);
    done = 1'b0;
    tick();
    expect_out("t2_idle", 4'b0000, 2'd1, 1'b0, 1'b0, IDLE);
    tick();
`ifdef PRIO_ARB_RR_EN
    expect_out("t2_regnt", 4'b1000, 2'd3, 1'b1, 1'b0, BUSY);
`else
    expect_out("t2_regnt", 4'b0010, 2'd1, 1'b1, 1'b0, BUSY);
`endif

    // 3: owner withdraws, resource drains until done.
    do_reset();
    req = 4'b0100;
    tick();
    expect_out("t3_gnt", 4'b0100, 2'd2, 1'b1, 1'b0, BUSY);
    req = 4'b0000;
    tick();
    expect_out("t3_drain", 4'b0000, 2'd2, 1'b1, 1'b0, DRAIN);
    tick();
    expect_out("t3_drain2", 4'b0000, 2'd2, 1'b1, 1'b0, DRAIN);
    done = 1'b1;
    tick();
    expect_out("t3_release", 4'b0000, 2'd2, 1'b0, 1'b0, RECOVER);
    done = 1'b0;
    tick();
    expect_out("t3_idle", 4'b0000, 2'd2, 1'b0, 1'b0, IDLE);

    // 4: hold timer forces release after 16 grant cycles; done at the limit wins.
    do_reset();
    req = 4'b1000;
    tick();
    expect_out("t4_gnt", 4'b1000, 2'd3, 1'b1, 1'b0, BUSY);
    for (int i = 1; i < TMO; i++) begin
      tick();
      expect_out("t4_hold", 4'b1000, 2'd3, 1'b1, 1'b0, BUSY);
    end
    tick();
    expect_out("t4_timeout", 4'b0000, 2'd3, 1'b0, 1'b1, RECOVER);
    tick();
    expect_out("t4_idle", 4'b0000, 2'd3, 1'b0, 1'b0, IDLE);
    tick();
    expect_out("t4_regnt", 4'b1000, 2'd3, 1'b1, 1'b0, BUSY);
    for (int i = 1; i < TMO; i++) begin
      tick();
      expect_out("t4_hold2", 4'b1000, 2'd3, 1'b1, 1'b0, BUSY);
    end
    done = 1'b1;
    tick();
    expect_out("t4_done_at_limit", 4'b0000, 2'd3, 1'b0, 1'b0, RECOVER);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    expect_out("t4_idle2", 4'b0000, 2'd3, 1'b0, 1'b0, IDLE);

    // 5: all requesting, done after each grant: round-robin or fixed sequence.
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
`ifdef PRIO_ARB_RR_EN
      eid = 2'(g % 4);
`else
      eid = 2'd0;
`endif
      tick();
      expect_out("t5_gnt", 4'b0001 << eid, eid, 1'b1, 1'b0, BUSY);
      done = 1'b1;
      tick();
      expect_out("t5_recover", 4'b0000, eid, 1'b0, 1'b0, RECOVER);
      done = 1'b0;
      tick();
      expect_out("t5_idle", 4'b0000, eid, 1'b0, 1'b0, IDLE);
    end
    req = 4'b0000;

    // 6: reset in the 4th grant cycle, then done in IDLE is ignored.
    do_reset();
    req = 4'b0010;
    tick();
    expect_out("t6_gnt", 4'b0010, 2'd1, 1'b1, 1'b0, BUSY);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("t6_hold", 4'b0010, 2'd1, 1'b1, 1'b0, BUSY);
    end
    rst = 1'b1;
    tick();
    expect_out("t6_mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0, IDLE);
    rst  = 1'b0;
    req  = 4'b0000;
    done = 1'b1;
    tick();
    expect_out("t6_done_in_idle", 4'b0000, 2'd0, 1'b0, 1'b0, IDLE);
    done = 1'b0;

    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
